// File: rtl/dds_phase_accumulator.sv
// dds_phase_accumulator
//   Phase accumulator (NCO core) of the DDS chain. The rising edge of one
//   selectable clock_divider tap is the sample tick. Each tick adds the active
//   frequency tuning word to an ACC_W-bit accumulator. The truncated phase
//   (LUT address) goes out with a one-cycle valid pulse and a wrap flag.
//
//   Build option: define DDS_PHASE_DITHER_EN to add a 16-bit Galois LFSR.
//   The LFSR dithers the output phase only; acc and wrap are unchanged.
//
// Ports
//   fast_clock   in   system clock, all logic on the rising edge
//   rst          in   asynchronous active-high reset
//   slow_clock   in   [DIV_W]  divider taps, synchronous to fast_clock
//   tap_sel      in   [4]      tap index; values >= DIV_W select tap DIV_W-1
//   ftw          in   [ACC_W]  frequency tuning word
//   ftw_valid    in   ftw offered
//   ftw_ready    out  block can accept a word
//   phase_clr    in   synchronous accumulator clear (drops a coincident tick)
//   phase        out  [OUT_W]  acc[ACC_W-1 -: OUT_W], registered
//   phase_valid  out  one-cycle pulse per processed tick
//   wrap         out  accumulator carry-out, qualified by phase_valid
//
// FSM states
//   S_IDLE | ready for a new word; increment is act_ftw
//   S_PEND | word held in pend_ftw; it becomes active on the next processed tick

module dds_phase_accumulator #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 10,
  parameter int DIV_W = 10
) (
  input  logic             fast_clock,
  input  logic             rst,
  input  logic [DIV_W-1:0] slow_clock,
  input  logic [3:0]       tap_sel,
  input  logic [ACC_W-1:0] ftw,
  input  logic             ftw_valid,
  output logic             ftw_ready,
  input  logic             phase_clr,
  output logic [OUT_W-1:0] phase,
  output logic             phase_valid,
  output logic             wrap
);

  typedef enum logic {S_IDLE, S_PEND} state_t;

  localparam logic [3:0] TAP_MAX = 4'(DIV_W - 1);

  state_t           state_q;
  logic             ready_q;
  logic             tap_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] act_ftw_q;
  logic [ACC_W-1:0] pend_ftw_q;
  logic [OUT_W-1:0] phase_q;
  logic             phase_valid_q;
  logic             wrap_q;

  logic [3:0]       sel_idx;
  logic             tap_cur;
  logic             tick;
  logic             proc_tick;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_d;
  logic [OUT_W-1:0] phase_d;

  assign sel_idx   = (32'(tap_sel) >= DIV_W) ? TAP_MAX : tap_sel;
  assign tap_cur   = slow_clock[sel_idx];
  assign tick      = tap_cur & ~tap_q;
  // A tick coinciding with phase_clr is dropped entirely, including the commit.
  assign proc_tick = tick & ~phase_clr;

  // The pending word applies on the same tick that commits it.
  assign inc   = (state_q == S_PEND) ? pend_ftw_q : act_ftw_q;
  assign sum   = {1'b0, acc_q} + {1'b0, inc};
  assign acc_d = sum[ACC_W-1:0];

`ifdef DDS_PHASE_DITHER_EN
  // LFSR word sits in the 16 bits just below the phase LSB.
  localparam int DSH = ACC_W - OUT_W - 16;

  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_d;
  logic [ACC_W-1:0] dith;
  logic [ACC_W-1:0] dith_sum;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign dith     = {{(ACC_W-16){1'b0}}, lfsr_q} << DSH;
  assign dith_sum = acc_d + dith;
  assign phase_d  = dith_sum[ACC_W-1 -: OUT_W];

  always_ff @(posedge fast_clock or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else if (proc_tick) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign phase_d = acc_d[ACC_W-1 -: OUT_W];
`endif

  always_ff @(posedge fast_clock or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b0;
      tap_q         <= 1'b0;
      acc_q         <= '0;
      act_ftw_q     <= '0;
      pend_ftw_q    <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      tap_q <= tap_cur;

      // Handshake keeps running through phase_clr.
      case (state_q)
        S_IDLE: begin
          if (ftw_valid && ready_q) begin
            pend_ftw_q <= ftw;
            state_q    <= S_PEND;
            ready_q    <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_PEND: begin
          if (proc_tick) begin
            act_ftw_q <= pend_ftw_q;
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
        end
      endcase

      if (phase_clr) begin
        acc_q         <= '0;
        phase_q       <= '0;
        phase_valid_q <= 1'b0;
        wrap_q        <= 1'b0;
      end else if (tick) begin
        acc_q         <= acc_d;
        phase_q       <= phase_d;
        phase_valid_q <= 1'b1;
        wrap_q        <= sum[ACC_W];
      end else begin
        phase_valid_q <= 1'b0;
        wrap_q        <= 1'b0;
      end
    end
  end

  assign ftw_ready   = ready_q;
  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign wrap        = wrap_q;

endmodule

// File: doc/dds_phase_accumulator.md
# dds_phase_accumulator

Phase accumulator (NCO core) of the DDS chain, directly downstream of `clock_divider`. Consumes the divider's `slow_clock` tap bus and uses the rising edge of one selectable tap as the sample tick. On each tick it adds a handshaked frequency tuning word to an `ACC_W`-bit accumulator. It emits the truncated phase (LUT address) with a valid pulse and a wrap flag to the waveform-lookup stage.

## Interface
- `ACC_W`, 32, accumulator width.
- `OUT_W`, 10, output phase width (LUT address); `ACC_W - OUT_W >= 16` required.
- `DIV_W`, 10, width of divider tap bus.

- `fast_clock`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `slow_clock`  in  DIV_W  divider taps from `clock_divider`, synchronous to `fast_clock`.
- `tap_sel`  in  4  tap index for the sample tick; values `>= DIV_W` select tap `DIV_W-1`.
- `ftw`  in  ACC_W  frequency tuning word.
- `ftw_valid`  in  1  `ftw` offered.
- `ftw_ready`  out  1  block can accept a word.
- `phase_clr`  in  1  synchronous accumulator clear.
- `phase`  out  OUT_W  `acc[ACC_W-1 -: OUT_W]`, registered.
- `phase_valid`  out  1  one-cycle pulse per processed tick.
- `wrap`  out  1  accumulator carry-out on that tick; qualified by `phase_valid`.

## Operation
- **Tick detect:** `tap_q` registers `slow_clock[sel]` every cycle. `tick = slow_clock[sel] & ~tap_q`. `tap_q` resets to 0; the divider also resets to 0, so no tick occurs out of reset.
- **FTW handshake:** two-state FSM.
  - IDLE (`ftw_ready=1`): on `ftw_valid & ftw_ready`, capture `ftw` into `pend_ftw`, go to PEND.
  - PEND (`ftw_ready=0`): on the next processed tick, `act_ftw <= pend_ftw`, go to IDLE.
- **Accumulate:** on a processed tick, `sum = acc + inc` (ACC_W+1 bits), where `inc = pend_ftw` in PEND and `act_ftw` otherwise. The new word therefore applies on the same tick it is committed.
  - `acc <= sum[ACC_W-1:0]`, `wrap <= sum[ACC_W]`, `phase_valid <= 1`.
- **No tick:** `phase_valid <= 0` and `wrap <= 0`; `phase` holds its value.
- **`phase_clr`:** highest priority. `acc <= 0`, `phase <= 0`, `phase_valid <= 0`, `wrap <= 0`.
  - A coincident tick is dropped.
  - FSM state and `pend_ftw` are preserved.
  - The handshake still operates.
- **`tap_sel` change:** may cause one spurious or missed tick. Software changes `tap_sel` with `phase_clr` asserted.
- **Modulo behaviour:** `ftw=0` freezes phase but `phase_valid` still pulses. Arithmetic is modulo `2^ACC_W`; there is no saturation.

## Timing
- **Latency:** tap rising edge visible in cycle t → `phase`, `phase_valid`, `wrap` valid in cycle t+1.
- **Tick rate:** at most one tick every 2 cycles (tap 0 toggling every cycle).
- **Ready after commit:** `ftw_ready` returns high the cycle after the commit tick. With `ftw_valid` held, the next word is captured in that cycle.
- **Reset values:**
  - Outputs: `phase=0`, `phase_valid=0`, `wrap=0`, `ftw_ready=0` while `rst` is high.
  - Internal state: `acc=0`, `act_ftw=0`, `pend_ftw=0`, FSM=IDLE.
  - `ftw_ready` rises on the first clock edge after `rst` deasserts.
- **Reset mid-PEND:** the pending word is discarded.

## Configuration
- **`DDS_PHASE_DITHER_EN` defined:**
  - Adds a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed `16'hACE1` on reset), advanced once per processed tick.
  - Output `phase = (sum[ACC_W-1:0] + ({LFSR, zeros} aligned to the 16 bits just below the phase LSB))[ACC_W-1 -: OUT_W]`, computed modulo `2^ACC_W`.
  - Dither affects the output only; `acc` and `wrap` are unaffected.
  - `phase_clr` forces `phase=0` and does not reseed the LFSR.
- **Undefined:** no LFSR; plain truncation as above.

## Test plan
- **Unit step:** `ACC_W=32`, `OUT_W=10`, `tap_sel=0`, load `ftw=32'h0040_0000` → `phase` 1,2,3… on successive `phase_valid`. On tick 1024: `phase=0`, `wrap=1`. Ticks arrive every 2 cycles.
- **Half-scale:** `ftw=32'h8000_0000` → `phase` alternates 512, 0; `wrap=1` on every second tick.
- **Handshake:** offer A=`32'h0040_0000`, then B=`32'h0080_0000` immediately.
  - `ftw_ready` low until A commits.
  - B is captured the cycle after A's commit tick.
  - Increments go 1 (from A), then 2 (from B) per tick.
- **Clear/tick collision:** assert `phase_clr` on a tick cycle with `phase=37` → next cycle `phase=0`, `phase_valid=0`. The next tick gives `phase=ftw` step 1.
- **Reset mid-operation:** `rst` high during PEND at `phase=100` → all outputs 0 immediately. After release, `ftw_ready=1`, and ticks produce no phase advance (`act_ftw=0`).
- **Dither build:** with `DDS_PHASE_DITHER_EN` and `ftw=32'h0040_0000` → `phase` differs from the undithered sequence by at most +1 LSB. `wrap` timing is identical.
